// File: rtl/hdmi_period_sequencer_if.sv
// hdmi_period_sequencer_if
// Raster and TMDS-period bus between the period sequencer (master) and the
// packet source / TMDS channel encoders (slave). Clock and reset stay outside
// the interface as plain ports of the sequencer.
interface hdmi_period_sequencer_if;

    // Packet handshake
    logic       packet_pending;     // source has a 32-word packet ready
    logic       packet_ack;         // one-cycle pulse on the last data word
    logic [4:0] packet_word_idx;    // word index during island data, else 0

    // Raster position and syncs
    logic [9:0] cx;                 // current column
    logic [9:0] cy;                 // current line
    logic       hsync;              // active-low
    logic       vsync;              // active-low

    // Period classification for the channel encoders
    logic [2:0] mode;               // TMDS period type of the current pixel
    logic [3:0] ctl;                // CTL3..0 for channels 1/2
    logic       video_data_enable;  // high iff mode is video data

    // Sequencer side
    modport master (
        input  packet_pending,
        output packet_ack, packet_word_idx,
        output cx, cy, hsync, vsync,
        output mode, ctl, video_data_enable
    );

    // Packet source / encoder side
    modport slave (
        output packet_pending,
        input  packet_ack, packet_word_idx,
        input  cx, cy, hsync, vsync,
        input  mode, ctl, video_data_enable
    );

endinterface

// File: rtl/hdmi_period_sequencer.sv
// hdmi_period_sequencer
// Pixel-domain raster counter, sync generator and TMDS period scheduler.
// Every pixel clock is classified as control, video preamble / guard band /
// data, or data-island preamble / guard band / data. At most one 32-word
// packet is placed in each horizontal blanking interval.
//
// Build option: define HDMI_PERIOD_SEQ_DVI_EN for DVI-only output (no data
// islands, no video preamble or guard band, packet_pending ignored).
module hdmi_period_sequencer #(
    parameter int FRAME_WIDTH    = 800,  // total pixels per line
    parameter int FRAME_HEIGHT   = 525,  // total lines per frame
    parameter int SCREEN_START_X = 160,  // first active pixel column
    parameter int SCREEN_START_Y = 45,   // first active line
    parameter int HSYNC_START    = 16,   // first cx with hsync asserted
    parameter int HSYNC_LEN      = 96,   // hsync width in pixels
    parameter int VSYNC_START    = 10,   // first cy with vsync asserted
    parameter int VSYNC_LEN      = 2,    // vsync height in lines
    parameter int DI_START       = 0     // cx of the first island preamble cycle
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    hdmi_period_sequencer_if.master bus
);

    // ------------------------------------------------------------------
    // Period encoding seen by the TMDS channel encoders
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        PERIOD_CTRL     = 3'd0,
        PERIOD_VID_PRE  = 3'd1,
        PERIOD_VID_GB   = 3'd2,
        PERIOD_VID_DATA = 3'd3,
        PERIOD_DI_PRE   = 3'd4,
        PERIOD_DI_GB    = 3'd5,
        PERIOD_DI_DATA  = 3'd6
    } period_e;

    localparam logic [3:0] CTL_NONE    = 4'b0000;
    localparam logic [3:0] CTL_VID_PRE = 4'b0001;
    localparam logic [3:0] CTL_DI_PRE  = 4'b0101;

    // Raster landmarks, pre-sized to the 10-bit counters
    localparam logic [9:0] X_LAST   = 10'(FRAME_WIDTH - 1);
    localparam logic [9:0] Y_LAST   = 10'(FRAME_HEIGHT - 1);
    localparam logic [9:0] X_ACTIVE = 10'(SCREEN_START_X);
    localparam logic [9:0] Y_ACTIVE = 10'(SCREEN_START_Y);
    localparam logic [9:0] X_VPRE   = 10'(SCREEN_START_X - 10);
    localparam logic [9:0] X_VGB    = 10'(SCREEN_START_X - 2);
    localparam logic [9:0] HS_FIRST = 10'(HSYNC_START);
    localparam logic [9:0] HS_END   = 10'(HSYNC_START + HSYNC_LEN);
    localparam logic [9:0] VS_FIRST = 10'(VSYNC_START);
    localparam logic [9:0] VS_END   = 10'(VSYNC_START + VSYNC_LEN);

    // Island layout as offsets from DI_START
    localparam logic [9:0] DI_FIRST    = 10'(DI_START);
    localparam logic [9:0] DI_OFF_LGB  = 10'd8;   // leading guard band
    localparam logic [9:0] DI_OFF_DATA = 10'd10;  // first packet word
    localparam logic [9:0] DI_OFF_ACK  = 10'd41;  // last packet word
    localparam logic [9:0] DI_OFF_TGB  = 10'd42;  // trailing guard band
    localparam logic [9:0] DI_LEN      = 10'd44;  // flag clears here
    localparam logic [9:0] DI_END      = 10'(DI_START + 44);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DI_START + 44 > SCREEN_START_X - 10) begin : g_di_overlap_check
        $error("hdmi_period_sequencer: DI_START+44 must be <= SCREEN_START_X-10 so islands cannot overlap the video preamble");
    end

    if (FRAME_WIDTH > 1024 || FRAME_HEIGHT > 1024) begin : g_counter_width_check
        $error("hdmi_period_sequencer: FRAME_WIDTH and FRAME_HEIGHT must fit the 10-bit raster counters");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [9:0] cx_q,     cx_d;
    logic [9:0] cy_q,     cy_d;
    logic       hsync_q,  hsync_d;
    logic       vsync_q,  vsync_d;
    period_e    mode_q,   mode_d;
    logic [3:0] ctl_q,    ctl_d;
    logic       vde_q,    vde_d;
    logic       ack_q,    ack_d;
    logic [4:0] idx_q,    idx_d;
    logic       island_q, island_d;   // a packet is committed to the current line

    // Decode helpers
    logic [9:0] di_off;
    logic       video_line;

    // Raster counters: cx every clock, cy on each cx wrap.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no path leaves it unassigned and no latch is inferred.
        cx_d = cx_q + 10'd1;
        cy_d = cy_q;
        if (cx_q == X_LAST) begin
            cx_d = '0;
            cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 10'd1;
        end
    end

`ifdef HDMI_PERIOD_SEQ_DVI_EN
    // DVI-only: islands never commit and the packet source is not observed.
    logic unused_packet_pending;
    assign unused_packet_pending = bus.packet_pending;

    always_comb begin
        island_d = 1'b0;
    end
`else
    // Island arbitration: commit on the last pixel of a line, release after the trailing guard band.
    always_comb begin
        island_d = island_q;
        if (cx_q == X_LAST) begin
            island_d = bus.packet_pending;
        end else if (cx_d == DI_END) begin
            island_d = 1'b0;
        end
    end
`endif

    // Next-pixel classification; decoded from the next raster position so registered outputs line up with cx/cy.
    always_comb begin
        mode_d     = PERIOD_CTRL;
        ctl_d      = CTL_NONE;
        ack_d      = 1'b0;
        idx_d      = '0;
        di_off     = cx_d - DI_FIRST;
        video_line = (cy_d >= Y_ACTIVE);

        hsync_d = !((cx_d >= HS_FIRST) && (cx_d < HS_END));
        vsync_d = !((cy_d >= VS_FIRST) && (cy_d < VS_END));

        // Video periods take priority over islands.
        if (video_line && (cx_d >= X_ACTIVE)) begin
            mode_d = PERIOD_VID_DATA;
        end
`ifndef HDMI_PERIOD_SEQ_DVI_EN
        else if (video_line && (cx_d >= X_VPRE) && (cx_d < X_VGB)) begin
            mode_d = PERIOD_VID_PRE;
            ctl_d  = CTL_VID_PRE;
        end else if (video_line && (cx_d >= X_VGB)) begin
            mode_d = PERIOD_VID_GB;
        end else if (island_d && (di_off < DI_LEN)) begin
            // di_off wraps to a large value left of DI_START, so one compare bounds both ends.
            if (di_off < DI_OFF_LGB) begin
                mode_d = PERIOD_DI_PRE;
                ctl_d  = CTL_DI_PRE;
            end else if (di_off < DI_OFF_DATA || di_off >= DI_OFF_TGB) begin
                mode_d = PERIOD_DI_GB;
            end else begin
                mode_d = PERIOD_DI_DATA;
                idx_d  = 5'(di_off - DI_OFF_DATA);
            end
            ack_d = (di_off == DI_OFF_ACK);
        end
`endif

        vde_d = (mode_d == PERIOD_VID_DATA);
    end

    // Register every output so the whole bus changes together on the pixel clock.
    always_ff @(posedge clk_pixel or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
        if (reset) begin
            cx_q     <= '0;
            cy_q     <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            mode_q   <= PERIOD_CTRL;
            ctl_q    <= CTL_NONE;
            vde_q    <= 1'b0;
            ack_q    <= 1'b0;
            idx_q    <= '0;
            island_q <= 1'b0;
        end else begin
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            mode_q   <= mode_d;
            ctl_q    <= ctl_d;
            vde_q    <= vde_d;
            ack_q    <= ack_d;
            idx_q    <= idx_d;
            island_q <= island_d;
        end
    end

    // Drive the bus straight from the registers.
    assign bus.cx                = cx_q;
    assign bus.cy                = cy_q;
    assign bus.hsync             = hsync_q;
    assign bus.vsync             = vsync_q;
    assign bus.mode              = mode_q;
    assign bus.ctl               = ctl_q;
    assign bus.video_data_enable = vde_q;
    assign bus.packet_ack        = ack_q;
    assign bus.packet_word_idx   = idx_q;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// tb_hdmi_period_sequencer
// Scoreboard bench: a reference model pushes the expected bus state for each
// pixel clock; a monitor pops and compares on the opposite clock edge.
// A reduced raster keeps full frames short.
module tb_hdmi_period_sequencer;

    localparam int W   = 200;
    localparam int H   = 60;
    localparam int SSX = 60;
    localparam int SSY = 10;
    localparam int HS  = 4;
    localparam int HL  = 20;
    localparam int VS  = 2;
    localparam int VL  = 2;
    localparam int DI  = 4;

    typedef struct packed {
        logic [9:0] cx;
        logic [9:0] cy;
        logic       hsync;
        logic       vsync;
        logic [2:0] mode;
        logic [3:0] ctl;
        logic       vde;
        logic       ack;
        logic [4:0] idx;
    } obs_t;

    localparam obs_t RESET_EXP = '{cx: 10'd0, cy: 10'd0, hsync: 1'b1, vsync: 1'b1,
                                   mode: 3'd0, ctl: 4'd0, vde: 1'b0, ack: 1'b0, idx: 5'd0};

    logic clk_pixel = 1'b0;
    logic reset     = 1'b0;

    hdmi_period_sequencer_if bus();

    hdmi_period_sequencer #(
        .FRAME_WIDTH   (W),
        .FRAME_HEIGHT  (H),
        .SCREEN_START_X(SSX),
        .SCREEN_START_Y(SSY),
        .HSYNC_START   (HS),
        .HSYNC_LEN     (HL),
        .VSYNC_START   (VS),
        .VSYNC_LEN     (VL),
        .DI_START      (DI)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    function automatic string fmt(input obs_t o);
        return $sformatf("cx=%0d cy=%0d hs=%b vs=%b mode=%0d ctl=%b vde=%b ack=%b idx=%0d",
                         o.cx, o.cy, o.hsync, o.vsync, o.mode, o.ctl, o.vde, o.ack, o.idx);
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %s, required %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_flag(input string name, input bit got, input bit exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.cx    = bus.cx;
        o.cy    = bus.cy;
        o.hsync = bus.hsync;
        o.vsync = bus.vsync;
        o.mode  = bus.mode;
        o.ctl   = bus.ctl;
        o.vde   = bus.video_data_enable;
        o.ack   = bus.packet_ack;
        o.idx   = bus.packet_word_idx;
        return o;
    endfunction

    // Expected bus state for pixel (x, y) given whether this line carries a packet.
    function automatic obs_t expect_at(input int x, input int y, input bit island);
        obs_t e = '0;
        int   d = x - DI;
        e.cx    = 10'(x);
        e.cy    = 10'(y);
        e.hsync = !(x >= HS && x < HS + HL);
        e.vsync = !(y >= VS && y < VS + VL);
        if (y >= SSY && x >= SSX) begin
            e.mode = 3'd3;
        end
`ifndef HDMI_PERIOD_SEQ_DVI_EN
        else if (y >= SSY && x >= SSX - 10 && x <= SSX - 3) begin
            e.mode = 3'd1;
            e.ctl  = 4'b0001;
        end else if (y >= SSY && x >= SSX - 2) begin
            e.mode = 3'd2;
        end else if (island && d >= 0 && d <= 43) begin
            if (d <= 7) begin
                e.mode = 3'd4;
                e.ctl  = 4'b0101;
            end else if (d <= 9 || d >= 42) begin
                e.mode = 3'd5;
            end else begin
                e.mode = 3'd6;
                e.idx  = 5'(d - 10);
            end
            e.ack = (d == 41);
        end
`endif
        e.vde = (e.mode == 3'd3);
        return e;
    endfunction

    // Reference model: pixel count since reset release plus per-line packet commitment.
    int model_n        = 0;
    bit model_island   = 1'b0;
    bit model_in_reset = 1'b1;

    initial begin
        forever begin
            @(posedge clk_pixel or posedge reset or negedge reset);
            if (reset) begin
                model_in_reset = 1'b1;
            end else if (model_in_reset) begin
                model_in_reset = 1'b0;
                model_n        = 0;
                model_island   = 1'b0;
                exp_q.push_back(expect_at(0, 0, 1'b0));
            end else begin
                if (model_n % W == W - 1) model_island = bus.packet_pending;
                model_n++;
                exp_q.push_back(expect_at(model_n % W, (model_n / W) % H, model_island));
            end
        end
    end

    // Monitor: compare on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_pixel);
            if (reset) begin
                exp_q.delete();
                check("reset_state", sample(), RESET_EXP);
            end else begin
                check_flag("expect_available", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("pixel", sample(), exp_q.pop_front());
            end
        end
    end

    // Bounded wait for a given column, seen at a falling edge.
    task automatic wait_cx(input int x);
        int n = 0;
        do begin
            @(negedge clk_pixel);
            n++;
        end while (bus.cx != 10'(x) && n < 2 * W * H);
        check_flag($sformatf("reach_cx_%0d", x), bus.cx == 10'(x), 1'b1);
    endtask

    task automatic random_pending(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_pixel);
            bus.packet_pending = ($urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        bus.packet_pending = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk_pixel);
        #2 reset = 1'b0;

        // Full frame with no packets: wraps, syncs and video periods.
        repeat (W * H + W) @(negedge clk_pixel);

        // Committed island; pending dropped during its preamble.
        wait_cx(W - 3);
        bus.packet_pending = 1'b1;
        wait_cx(DI + 3);
        bus.packet_pending = 1'b0;

        // Pending raised after the sample point: island only on the following line.
        wait_cx(W - 1);
        wait_cx(DI + 5);
        bus.packet_pending = 1'b1;
        wait_cx(W - 1);
        wait_cx(DI + 46);
        bus.packet_pending = 1'b0;

        // Randomized packet availability over many lines.
        random_pending(8000);

        // Reset during island data: no ack, clean restart.
        bus.packet_pending = 1'b1;
        wait_cx(W - 1);
        wait_cx(20);
        @(posedge clk_pixel);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk_pixel);
        #2 reset = 1'b0;

        random_pending(3 * W);
        repeat (2) @(negedge clk_pixel);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_period_sequencer.md
Name: hdmi_period_sequencer

Overview:
- Pixel-domain timing and period scheduler for the HDMI transmitter core. It generates the raster counters and sync signals.
- Classifies every pixel clock into one TMDS period type: control, video preamble, video guard band, video data, data-island preamble, data-island guard band, or data-island data.
- Arbitrates one 32-cycle packet per horizontal blanking interval.
- Sits directly upstream of the three TMDS channel encoders; its mode/ctl outputs select what each channel encodes.

Parameters:
- FRAME_WIDTH, 800, total pixels per line
- FRAME_HEIGHT, 525, total lines per frame
- SCREEN_START_X, 160, first active pixel column
- SCREEN_START_Y, 45, first active line
- HSYNC_START, 16, first cx with hsync asserted
- HSYNC_LEN, 96, hsync width in pixels
- VSYNC_START, 10, first cy with vsync asserted
- VSYNC_LEN, 2, vsync height in lines
- DI_START, 0, cx of the first data-island preamble cycle; DI_START+44 must be <= SCREEN_START_X-10

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  asynchronous reset, active-high
- packet_pending  in  1  packet source has a 32-word packet ready
- cx  out  10  current column, 0..FRAME_WIDTH-1
- cy  out  10  current line, 0..FRAME_HEIGHT-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- mode  out  3  0 ctrl, 1 video preamble, 2 video GB, 3 video data, 4 DI preamble, 5 DI GB, 6 DI data
- ctl  out  4  CTL3..0 for channels 1/2
- video_data_enable  out  1  high iff mode==3
- packet_ack  out  1  one-cycle pulse when the packet is consumed
- packet_word_idx  out  5  word index 0..31 during DI data, else 0

Behaviour:
- Reset state: all outputs registered. cx=0, cy=0, hsync=1, vsync=1, mode=0, ctl=0000, video_data_enable=0, packet_ack=0, packet_word_idx=0, island flag clear.
- Reset asserted mid-island or mid-video: all outputs return to reset values immediately; the packet is not acked.
- Counters: cx increments every clock and wraps from FRAME_WIDTH-1 to 0. cy increments when cx wraps and itself wraps from FRAME_HEIGHT-1 to 0.
- Active pixel: cx>=SCREEN_START_X and cy>=SCREEN_START_Y.
- Sync: hsync=0 for HSYNC_START<=cx<HSYNC_START+HSYNC_LEN. vsync=0 for VSYNC_START<=cy<VSYNC_START+VSYNC_LEN. Both are aligned to the same cycle as cx/cy.
- Video periods, on lines where cy>=SCREEN_START_Y:
  - preamble (mode 1, ctl=0001) at cx SCREEN_START_X-10..-3
  - guard band (mode 2) at cx -2..-1
  - video data (mode 3) for active pixels
- Island arbitration: packet_pending is sampled in the cycle where cx==FRAME_WIDTH-1. If it is high, the island flag is set for the following line and the island is committed; deasserting packet_pending later is ignored.
- Island sequence, relative to DI_START:
  - preamble (mode 4, ctl=0101) at +0..+7
  - leading GB (mode 5) at +8..+9
  - data (mode 6) at +10..+41; packet_word_idx counts 0..31
  - trailing GB (mode 5) at +42..+43
  - flag clears at +44
- packet_ack is high exactly at +41, the last data word.
- Islands are allowed on every line, including vertical blanking lines and vsync lines.
- All other cycles: mode=0, ctl=0000.
- Priority: video periods win over islands. This cannot overlap given the DI_START parameter constraint; an elaboration-time $error fires if the constraint is violated.

Optional Feature:
- Macro: HDMI_PERIOD_SEQ_DVI_EN.
- Defined: DVI-only output. No islands and no video preamble/guard band. mode is only 0 or 3, packet_ack stays 0, packet_pending is ignored.
- Undefined: full HDMI behaviour as above.

Test Plan:
- Release reset, packet_pending=0, run one full frame. Expect cx wrapping 799->0 and cy wrapping 524->0. Expect hsync low for cx 16..111, vsync low for cy 10..11, and mode only 0/1/2/3.
- Line cy=100: mode=1 at cx 150..157 with ctl=0001; mode=2 at cx 158..159; mode=3 and video_data_enable=1 at cx 160..799.
- packet_pending=1 before cx=799 of line 49: on line 50 expect mode=4 at cx 0..7, mode=5 at cx 8..9 and 42..43, mode=6 at cx 10..41 with packet_word_idx 0..31, and a single packet_ack at cx=41.
- Raise packet_pending at cx=5, after the sample point: expect no island that line and an island on the next line. Drop packet_pending at cx=3 of a committed island: the island still completes with its ack.
- Assert reset at cx=20 during DI data: expect mode=0, packet_word_idx=0, no ack, cx=0 the next cycle after reset release.
- Build with HDMI_PERIOD_SEQ_DVI_EN and packet_pending=1 for a whole frame: expect modes 4..6 never appear, no mode 1/2, and packet_ack never asserted.
